battleship_turn_ctrl: RTL and testbench
=======================================

# battleship_turn_ctrl

Game-sequencing controller for the battleship top level. It owns the ship-count selection, the player placement phase, the PC placement handshake, alternating attack turns, and the life counters. It drives the board/attack datapath through single-cycle request pulses and waits for its done strobes. Its phase and life outputs feed the VGA renderer and the 7-segment life displays.

## Interface
Parameters:
- TURN_TIMEOUT, 500: clock cycles the player has per turn before the turn is forfeited; must be ≥1.
- PC_DELAY, 50: idle cycles before the PC fires; must be ≥1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- attack  in  1  raw attack button, active-high, asynchronous.
- poner  in  1  raw place button, active-high, asynchronous.
- barcos  in  3  requested ship count; sampled only on SELECT exit.
- place_ok  in  1  board reports the current cursor placement is legal; combinational, same cycle.
- pc_place_done  in  1  PC placer finished; level or pulse.
- fire_done  in  1  board finished evaluating the shot; single-cycle strobe.
- fire_hit  in  1  qualifies fire_done: the shot hit a ship cell.
- fire_repeat  in  1  qualifies fire_done: the cell was already shot; has priority over fire_hit.
- place_we  out  1  one-cycle pulse: write the current ship into the player board.
- ship_len  out  3  length of the ship being placed (1..5).
- pc_place_start  out  1  one-cycle pulse starting the PC placer.
- fire_req  out  1  one-cycle pulse requesting shot evaluation.
- fire_side  out  1  0 = player shoots the PC board; 1 = PC shoots the player board. Held stable from fire_req until fire_done.
- life_player  out  4  remaining player ship cells.
- life_pc  out  4  remaining PC ship cells.
- phase  out  3  current state encoding, listed below.
- game_over  out  1  high in state DONE.
- player_won  out  1  valid when game_over = 1.

## Operation
- Button conditioning: attack and poner each pass through a 2-flop synchronizer, then rising-edge detection, producing internal one-cycle edge pulses. A held button yields exactly one pulse.
- Ship count: N = clamp(barcos), where 0 → 1 and 6 or 7 → 5. On SELECT exit, both life_player and life_pc are loaded with N(N+1)/2 (range 1..15), and ship_len is loaded with N.
- States (phase value):
  - SELECT (0): on an attack edge → PLACE.
  - PLACE (1): on a poner edge with place_ok = 1, pulse place_we. Then:
    - if ship_len = 1, pulse pc_place_start and go to PC_PLACE;
    - otherwise decrement ship_len.
    - A poner edge with place_ok = 0 is ignored.
  - PC_PLACE (2): when pc_place_done = 1 → P_TURN; the turn timer is loaded with TURN_TIMEOUT.
  - P_TURN (3): the timer decrements every cycle.
    - On an attack edge: pulse fire_req with fire_side = 0, go to P_WAIT.
    - If the timer reaches 0 with no edge: go to C_TURN (turn forfeited, no shot).
  - P_WAIT (4): on fire_done:
    - repeat → P_TURN; the timer is NOT reloaded.
    - hit → decrement life_pc; if the result is 0 → DONE with player_won = 1, else → C_TURN.
    - miss → C_TURN.
  - C_TURN (5): the delay counter is loaded with PC_DELAY on entry. At 0: pulse fire_req with fire_side = 1, go to C_WAIT.
  - C_WAIT (6): on fire_done:
    - repeat → C_TURN (delay reloaded).
    - hit → decrement life_player; if the result is 0 → DONE with player_won = 0, else → P_TURN (timer reloaded).
    - miss → P_TURN (timer reloaded).
  - DONE (7): game_over = 1. An attack edge → SELECT; lives, ship_len, and player_won are cleared.
- Life decrements saturate at 0.
- Boundary conditions:
  - Timer expiry and an attack edge in the same cycle: the attack wins and the shot is fired.
  - attack and poner edges in the same cycle in PLACE: poner is processed, attack is ignored.
  - fire_done outside P_WAIT/C_WAIT is ignored.
  - pc_place_done outside PC_PLACE is ignored.

## Timing
- Reset value of every output is 0, including phase = SELECT. Asserting reset mid-operation clears all pulses immediately and returns to SELECT.
- Button press to internal edge: the raw input rising before clk edge k produces the edge at edge k+2. The resulting output pulse or state change appears at edge k+3.
- place_we, pc_place_start, and fire_req are high for exactly 1 cycle, registered, and coincide with the state transition.
- fire_done to the next state, and to the life update: 1 cycle.
- Player turn length: TURN_TIMEOUT cycles from P_TURN entry to forfeit.
- PC shot: fire_req is asserted PC_DELAY + 1 cycles after C_TURN entry.
- Timer width: $clog2(TURN_TIMEOUT+1). Delay counter width: $clog2(PC_DELAY+1).

## Test plan
- Reset, then barcos = 2, attack press → phase = 1, ship_len = 2, life_player = life_pc = 3.
- In PLACE, press poner with place_ok = 0 → no place_we. Then two presses with place_ok = 1 → two place_we pulses and one pc_place_start. Then pc_place_done → phase = 3.
- barcos = 7 → N clamped to 5, lives = 15. barcos = 0 → lives = 1.
- Player shot: fire_done + fire_hit → life_pc decrements by 1, phase = 5. fire_req with fire_side = 1 appears PC_DELAY + 1 cycles later. fire_done + fire_repeat → fire_req is reissued after another delay.
- No attack press for TURN_TIMEOUT cycles → phase 3 → 5 with no fire_req from the player. An attack edge on the expiry cycle → the shot is fired instead.
- N = 1, player hit → game_over = 1, player_won = 1. Attack press → SELECT with lives = 0. Reset asserted during P_WAIT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/battleship_turn_ctrl.sv
// Battleship game sequencer: ship-count select, placement, alternating turns, lives.
// Ports: clk/reset(active-low async); attack/poner raw buttons; barcos ship count;
//   place_ok, pc_place_done, fire_done/fire_hit/fire_repeat from the board;
//   place_we, ship_len, pc_place_start, fire_req, fire_side to the board;
//   life_player, life_pc, phase, game_over, player_won to the displays.
module battleship_turn_ctrl #(
    parameter int TURN_TIMEOUT = 500,
    parameter int PC_DELAY     = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       attack,
    input  logic       poner,
    input  logic [2:0] barcos,
    input  logic       place_ok,
    input  logic       pc_place_done,
    input  logic       fire_done,
    input  logic       fire_hit,
    input  logic       fire_repeat,
    output logic       place_we,
    output logic [2:0] ship_len,
    output logic       pc_place_start,
    output logic       fire_req,
    output logic       fire_side,
    output logic [3:0] life_player,
    output logic [3:0] life_pc,
    output logic [2:0] phase,
    output logic       game_over,
    output logic       player_won
);

    localparam int TW = $clog2(TURN_TIMEOUT + 1);
    localparam int DW = $clog2(PC_DELAY + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(TURN_TIMEOUT);
    localparam logic [DW-1:0] D_LOAD = DW'(PC_DELAY);

    typedef enum logic [2:0] {
        SELECT   = 3'd0,
        PLACE    = 3'd1,
        PC_PLACE = 3'd2,
        P_TURN   = 3'd3,
        P_WAIT   = 3'd4,
        C_TURN   = 3'd5,
        C_WAIT   = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [DW-1:0] delay, delay_nxt;
    logic [2:0]    ship_nxt;
    logic [3:0]    lp_nxt, lc_nxt;
    logic          side_nxt, won_nxt, we_nxt, pcs_nxt, freq_nxt;

    // bit 2 is the previous synchronized level; edge is registered so the
    // FSM acts one cycle after the synchronizer output rises
    logic [2:0] atk_sync, pon_sync;
    logic       atk_edge, pon_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            atk_sync <= '0;
            pon_sync <= '0;
            atk_edge <= 1'b0;
            pon_edge <= 1'b0;
        end else begin
            atk_sync <= {atk_sync[1:0], attack};
            pon_sync <= {pon_sync[1:0], poner};
            atk_edge <= atk_sync[1] & ~atk_sync[2];
            pon_edge <= pon_sync[1] & ~pon_sync[2];
        end
    end

    logic [2:0] n_ships;
    logic [3:0] n_life;

    always_comb begin
        unique case (barcos)
            3'd0:       n_ships = 3'd1;
            3'd6, 3'd7: n_ships = 3'd5;
            default:    n_ships = barcos;
        endcase
        unique case (n_ships)
            3'd1:    n_life = 4'd1;
            3'd2:    n_life = 4'd3;
            3'd3:    n_life = 4'd6;
            3'd4:    n_life = 4'd10;
            default: n_life = 4'd15;
        endcase
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        delay_nxt = delay;
        ship_nxt  = ship_len;
        lp_nxt    = life_player;
        lc_nxt    = life_pc;
        side_nxt  = fire_side;
        won_nxt   = player_won;
        we_nxt    = 1'b0;
        pcs_nxt   = 1'b0;
        freq_nxt  = 1'b0;
        unique case (state)
            SELECT: begin
                if (atk_edge) begin
                    state_nxt = PLACE;
                    ship_nxt  = n_ships;
                    lp_nxt    = n_life;
                    lc_nxt    = n_life;
                end
            end
            PLACE: begin
                if (pon_edge && place_ok) begin
                    we_nxt = 1'b1;
                    if (ship_len <= 3'd1) begin
                        pcs_nxt   = 1'b1;
                        state_nxt = PC_PLACE;
                    end else begin
                        ship_nxt = ship_len - 3'd1;
                    end
                end
            end
            PC_PLACE: begin
                if (pc_place_done) begin
                    state_nxt = P_TURN;
                    timer_nxt = T_LOAD;
                end
            end
            P_TURN: begin
                if (timer != '0)
                    timer_nxt = timer - 1'b1;
                // the shot beats a forfeit landing on the same cycle
                if (atk_edge) begin
                    freq_nxt  = 1'b1;
                    side_nxt  = 1'b0;
                    state_nxt = P_WAIT;
                end else if (timer <= TW'(1)) begin
                    state_nxt = C_TURN;
                    delay_nxt = D_LOAD;
                end
            end
            P_WAIT: begin
                if (fire_done) begin
                    if (fire_repeat) begin
                        state_nxt = P_TURN;
                    end else if (fire_hit) begin
                        lc_nxt = (life_pc != '0) ? life_pc - 4'd1 : 4'd0;
                        if (life_pc <= 4'd1) begin
                            state_nxt = DONE;
                            won_nxt   = 1'b1;
                        end else begin
                            state_nxt = C_TURN;
                            delay_nxt = D_LOAD;
                        end
                    end else begin
                        state_nxt = C_TURN;
                        delay_nxt = D_LOAD;
                    end
                end
            end
            C_TURN: begin
                if (delay == '0) begin
                    freq_nxt  = 1'b1;
                    side_nxt  = 1'b1;
                    state_nxt = C_WAIT;
                end else begin
                    delay_nxt = delay - 1'b1;
                end
            end
            C_WAIT: begin
                if (fire_done) begin
                    if (fire_repeat) begin
                        state_nxt = C_TURN;
                        delay_nxt = D_LOAD;
                    end else begin
                        state_nxt = P_TURN;
                        timer_nxt = T_LOAD;
                        if (fire_hit) begin
                            lp_nxt = (life_player != '0) ? life_player - 4'd1 : 4'd0;
                            if (life_player <= 4'd1) begin
                                state_nxt = DONE;
                                won_nxt   = 1'b0;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (atk_edge) begin
                    state_nxt = SELECT;
                    lp_nxt    = '0;
                    lc_nxt    = '0;
                    ship_nxt  = '0;
                    won_nxt   = 1'b0;
                end
            end
            default: state_nxt = SELECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= SELECT;
            timer          <= '0;
            delay          <= '0;
            ship_len       <= '0;
            life_player    <= '0;
            life_pc        <= '0;
            fire_side      <= 1'b0;
            player_won     <= 1'b0;
            place_we       <= 1'b0;
            pc_place_start <= 1'b0;
            fire_req       <= 1'b0;
        end else begin
            state          <= state_nxt;
            timer          <= timer_nxt;
            delay          <= delay_nxt;
            ship_len       <= ship_nxt;
            life_player    <= lp_nxt;
            life_pc        <= lc_nxt;
            fire_side      <= side_nxt;
            player_won     <= won_nxt;
            place_we       <= we_nxt;
            pc_place_start <= pcs_nxt;
            fire_req       <= freq_nxt;
        end
    end

    assign phase     = state;
    assign game_over = (state == DONE);

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed self-checking bench for battleship_turn_ctrl.
// Short TURN_TIMEOUT / PC_DELAY keep the turn-timing scenarios brief.
module tb_battleship_turn_ctrl;

    localparam int T = 20;
    localparam int D = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       attack = 1'b0;
    logic       poner = 1'b0;
    logic [2:0] barcos = 3'd0;
    logic       place_ok = 1'b0;
    logic       pc_place_done = 1'b0;
    logic       fire_done = 1'b0;
    logic       fire_hit = 1'b0;
    logic       fire_repeat = 1'b0;
    logic       place_we;
    logic [2:0] ship_len;
    logic       pc_place_start;
    logic       fire_req;
    logic       fire_side;
    logic [3:0] life_player;
    logic [3:0] life_pc;
    logic [2:0] phase;
    logic       game_over;
    logic       player_won;

    int checks = 0;
    int errors = 0;

    battleship_turn_ctrl #(.TURN_TIMEOUT(T), .PC_DELAY(D)) dut (
        .clk(clk), .reset(reset), .attack(attack), .poner(poner),
        .barcos(barcos), .place_ok(place_ok), .pc_place_done(pc_place_done),
        .fire_done(fire_done), .fire_hit(fire_hit), .fire_repeat(fire_repeat),
        .place_we(place_we), .ship_len(ship_len), .pc_place_start(pc_place_start),
        .fire_req(fire_req), .fire_side(fire_side), .life_player(life_player),
        .life_pc(life_pc), .phase(phase), .game_over(game_over),
        .player_won(player_won)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // idle so the synchronizer sees low, then press; output appears on 4th edge
    task automatic press_attack();
        repeat (3) tick();
        attack = 1'b1;
        repeat (4) tick();
        attack = 1'b0;
    endtask

    task automatic press_poner();
        repeat (3) tick();
        poner = 1'b1;
        repeat (4) tick();
        poner = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({phase, life_player, life_pc, ship_len} !== 14'd0) begin
            errors++;
            $display("FAIL rst_state got ph=%0d lp=%0d lc=%0d sl=%0d want 0", phase, life_player, life_pc, ship_len);
        end
        checks++;
        if ({place_we, pc_place_start, fire_req, fire_side, game_over, player_won} !== 6'd0) begin
            errors++;
            $display("FAIL rst_flags got %b want 000000", {place_we, pc_place_start, fire_req, fire_side, game_over, player_won});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_clamp();
        barcos = 3'd7;
        press_attack();
        checks++;
        if (phase !== 3'd1 || ship_len !== 3'd5 || life_pc !== 4'd15 || life_player !== 4'd15) begin
            errors++;
            $display("FAIL clamp7 got ph=%0d sl=%0d lp=%0d lc=%0d want 1 5 15 15", phase, ship_len, life_player, life_pc);
        end
        repeat (3) tick();
        place_ok = 1'b1;
        attack = 1'b1;
        poner = 1'b1;
        repeat (4) tick();
        attack = 1'b0;
        poner = 1'b0;
        checks++;
        if (place_we !== 1'b1 || phase !== 3'd1 || ship_len !== 3'd4) begin
            errors++;
            $display("FAIL both_btn got we=%b ph=%0d sl=%0d want 1 1 4", place_we, phase, ship_len);
        end
        place_ok = 1'b0;
        do_reset();
        barcos = 3'd0;
        press_attack();
        checks++;
        if (ship_len !== 3'd1 || life_pc !== 4'd1 || life_player !== 4'd1) begin
            errors++;
            $display("FAIL clamp0 got sl=%0d lp=%0d lc=%0d want 1 1 1", ship_len, life_player, life_pc);
        end
        do_reset();
    endtask

    task automatic test_select();
        barcos = 3'd2;
        press_attack();
        checks++;
        if (phase !== 3'd1 || ship_len !== 3'd2 || life_player !== 4'd3 || life_pc !== 4'd3) begin
            errors++;
            $display("FAIL select got ph=%0d sl=%0d lp=%0d lc=%0d want 1 2 3 3", phase, ship_len, life_player, life_pc);
        end
    endtask

    task automatic test_place();
        place_ok = 1'b0;
        press_poner();
        checks++;
        if (place_we !== 1'b0 || ship_len !== 3'd2 || phase !== 3'd1) begin
            errors++;
            $display("FAIL place_bad got we=%b sl=%0d ph=%0d want 0 2 1", place_we, ship_len, phase);
        end
        pc_place_done = 1'b1;
        tick();
        pc_place_done = 1'b0;
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL pcdone_ignored got ph=%0d want 1", phase);
        end
        place_ok = 1'b1;
        press_poner();
        checks++;
        if (place_we !== 1'b1 || pc_place_start !== 1'b0 || ship_len !== 3'd1) begin
            errors++;
            $display("FAIL place1 got we=%b pcs=%b sl=%0d want 1 0 1", place_we, pc_place_start, ship_len);
        end
        tick();
        checks++;
        if (place_we !== 1'b0) begin
            errors++;
            $display("FAIL place1_width got we=%b want 0", place_we);
        end
        press_poner();
        checks++;
        if (place_we !== 1'b1 || pc_place_start !== 1'b1 || phase !== 3'd2) begin
            errors++;
            $display("FAIL place2 got we=%b pcs=%b ph=%0d want 1 1 2", place_we, pc_place_start, phase);
        end
        place_ok = 1'b0;
        fire_done = 1'b1;
        fire_hit = 1'b1;
        tick();
        fire_done = 1'b0;
        fire_hit = 1'b0;
        checks++;
        if (pc_place_start !== 1'b0 || phase !== 3'd2 || life_pc !== 4'd3) begin
            errors++;
            $display("FAIL pcplace_hold got pcs=%b ph=%0d lc=%0d want 0 2 3", pc_place_start, phase, life_pc);
        end
        pc_place_done = 1'b1;
        tick();
        pc_place_done = 1'b0;
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL to_pturn got ph=%0d want 3", phase);
        end
    endtask

    task automatic test_player_hit();
        press_attack();
        checks++;
        if (fire_req !== 1'b1 || fire_side !== 1'b0 || phase !== 3'd4) begin
            errors++;
            $display("FAIL pshot got req=%b side=%b ph=%0d want 1 0 4", fire_req, fire_side, phase);
        end
        tick();
        fire_done = 1'b1;
        fire_hit = 1'b1;
        tick();
        fire_done = 1'b0;
        fire_hit = 1'b0;
        checks++;
        if (life_pc !== 4'd2 || life_player !== 4'd3 || phase !== 3'd5) begin
            errors++;
            $display("FAIL phit got lc=%0d lp=%0d ph=%0d want 2 3 5", life_pc, life_player, phase);
        end
    endtask

    task automatic test_pc_shot();
        repeat (D) tick();
        checks++;
        if (fire_req !== 1'b0 || phase !== 3'd5) begin
            errors++;
            $display("FAIL pcdelay_early got req=%b ph=%0d want 0 5", fire_req, phase);
        end
        tick();
        checks++;
        if (fire_req !== 1'b1 || fire_side !== 1'b1 || phase !== 3'd6) begin
            errors++;
            $display("FAIL pcshot got req=%b side=%b ph=%0d want 1 1 6", fire_req, fire_side, phase);
        end
        tick();
        fire_done = 1'b1;
        fire_repeat = 1'b1;
        fire_hit = 1'b1;
        tick();
        fire_done = 1'b0;
        fire_repeat = 1'b0;
        fire_hit = 1'b0;
        checks++;
        if (phase !== 3'd5 || life_player !== 4'd3) begin
            errors++;
            $display("FAIL pcrepeat got ph=%0d lp=%0d want 5 3", phase, life_player);
        end
        repeat (D) tick();
        checks++;
        if (fire_req !== 1'b0) begin
            errors++;
            $display("FAIL pcreissue_early got req=%b want 0", fire_req);
        end
        tick();
        checks++;
        if (fire_req !== 1'b1 || fire_side !== 1'b1) begin
            errors++;
            $display("FAIL pcreissue got req=%b side=%b want 1 1", fire_req, fire_side);
        end
        tick();
        fire_done = 1'b1;
        tick();
        fire_done = 1'b0;
        checks++;
        if (phase !== 3'd3 || life_player !== 4'd3) begin
            errors++;
            $display("FAIL pcmiss got ph=%0d lp=%0d want 3 3", phase, life_player);
        end
    endtask

    task automatic test_timeout();
        int seen;
        seen = 0;
        for (int i = 0; i < T - 1; i++) begin
            tick();
            if (fire_req) seen++;
        end
        checks++;
        if (phase !== 3'd3 || seen != 0) begin
            errors++;
            $display("FAIL timeout_early got ph=%0d reqs=%0d want 3 0", phase, seen);
        end
        tick();
        checks++;
        if (phase !== 3'd5 || fire_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout got ph=%0d req=%b want 5 0", phase, fire_req);
        end
        repeat (D + 1) tick();
        tick();
        fire_done = 1'b1;
        fire_hit = 1'b1;
        tick();
        fire_done = 1'b0;
        fire_hit = 1'b0;
        checks++;
        if (phase !== 3'd3 || life_player !== 4'd2) begin
            errors++;
            $display("FAIL pchit got ph=%0d lp=%0d want 3 2", phase, life_player);
        end
    endtask

    task automatic test_expiry_attack();
        repeat (T - 4) tick();
        attack = 1'b1;
        repeat (3) tick();
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL expiry_pre got ph=%0d want 3", phase);
        end
        tick();
        attack = 1'b0;
        checks++;
        if (fire_req !== 1'b1 || fire_side !== 1'b0 || phase !== 3'd4) begin
            errors++;
            $display("FAIL expiry_shot got req=%b side=%b ph=%0d want 1 0 4", fire_req, fire_side, phase);
        end
    endtask

    task automatic test_win();
        do_reset();
        barcos = 3'd1;
        press_attack();
        place_ok = 1'b1;
        press_poner();
        place_ok = 1'b0;
        checks++;
        if (pc_place_start !== 1'b1 || phase !== 3'd2) begin
            errors++;
            $display("FAIL n1_place got pcs=%b ph=%0d want 1 2", pc_place_start, phase);
        end
        pc_place_done = 1'b1;
        tick();
        pc_place_done = 1'b0;
        press_attack();
        tick();
        fire_done = 1'b1;
        fire_hit = 1'b1;
        tick();
        fire_done = 1'b0;
        fire_hit = 1'b0;
        checks++;
        if (phase !== 3'd7 || game_over !== 1'b1 || player_won !== 1'b1 || life_pc !== 4'd0) begin
            errors++;
            $display("FAIL win got ph=%0d go=%b won=%b lc=%0d want 7 1 1 0", phase, game_over, player_won, life_pc);
        end
        press_attack();
        checks++;
        if (phase !== 3'd0 || game_over !== 1'b0 || player_won !== 1'b0 || life_player !== 4'd0 || ship_len !== 3'd0) begin
            errors++;
            $display("FAIL restart got ph=%0d go=%b won=%b lp=%0d sl=%0d want 0 0 0 0 0", phase, game_over, player_won, life_player, ship_len);
        end
    endtask

    task automatic test_reset_mid();
        barcos = 3'd3;
        press_attack();
        place_ok = 1'b1;
        repeat (3) press_poner();
        place_ok = 1'b0;
        pc_place_done = 1'b1;
        tick();
        pc_place_done = 1'b0;
        press_attack();
        checks++;
        if (phase !== 3'd4 || fire_req !== 1'b1 || life_pc !== 4'd6) begin
            errors++;
            $display("FAIL pre_rst got ph=%0d req=%b lc=%0d want 4 1 6", phase, fire_req, life_pc);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({phase, life_player, life_pc, ship_len, fire_req, game_over} !== 16'd0) begin
            errors++;
            $display("FAIL async_rst got ph=%0d lp=%0d lc=%0d sl=%0d req=%b go=%b want 0", phase, life_player, life_pc, ship_len, fire_req, game_over);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_select();
        test_place();
        test_player_hit();
        test_pc_shot();
        test_timeout();
        test_expiry_attack();
        test_win();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
